// File: rtl/mux32to1_top_if.sv
// Lane-select bus for the registered 32-to-1 selector: select, packed lanes, selected output.
interface mux32to1_top_if #(
    parameter int unsigned DATA_W = 1
);
    logic [4:0]             S;
    logic [32*DATA_W-1:0]   I;
    logic [DATA_W-1:0]      Y;

    modport master (
        output S,
        output I,
        input  Y
    );

    modport slave (
        input  S,
        input  I,
        output Y
    );
endinterface

// File: rtl/mux32to1_top.sv
// Registered 32-to-1 lane selector built as a 5-level tree of 2:1 muxes.
// Level n of the tree is steered by S[n-1]; the root (S[4]) splits lanes 0..15 from 16..31.
module mux32to1_top #(
    parameter int unsigned DATA_W = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux32to1_top_if.slave bus
);

    logic [DATA_W-1:0] w_l0 [32];
    logic [DATA_W-1:0] w_l1 [16];
    logic [DATA_W-1:0] w_l2 [8];
    logic [DATA_W-1:0] w_l3 [4];
    logic [DATA_W-1:0] w_l4 [2];
    logic [DATA_W-1:0] w_root;
    logic [DATA_W-1:0] r_y;

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            w_l0[k] = bus.I[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_l1[j] = bus.S[0] ? w_l0[2*j+1] : w_l0[2*j];
        end
    end

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_l2[j] = bus.S[1] ? w_l1[2*j+1] : w_l1[2*j];
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_l3[j] = bus.S[2] ? w_l2[2*j+1] : w_l2[2*j];
        end
    end

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            w_l4[j] = bus.S[3] ? w_l3[2*j+1] : w_l3[2*j];
        end
    end

    assign w_root = bus.S[4] ? w_l4[1] : w_l4[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_root;
        end
    end

    assign bus.Y = r_y;

endmodule

// File: tb/tb_mux32to1_top.sv
// Directed bench for mux32to1_top: vector table plus reset, hold and mid-stream reset sequences.
module tb_mux32to1_top;

    typedef struct {
        logic [4:0]  s;
        logic [31:0] i;
        logic        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    mux32to1_top_if #(.DATA_W(1)) bus ();

    mux32to1_top #(.DATA_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: Y=%b expected %b (S=%0d I=%h)", name, got, exp, bus.S, bus.I);
        end
    endtask

    // Apply S/I, clock once, then sample just after the edge.
    task automatic step(input logic [4:0] s, input logic [31:0] i, input logic exp,
                        input string name);
        bus.S = s;
        bus.I = i;
        @(posedge clk);
        #1;
        check(name, bus.Y, exp);
    endtask

    initial begin
        logic [31:0] one_hot;
        n_checks = 0;
        n_fail   = 0;

        // Sweep of S over I=640: only lanes 7 and 9 are set.
        for (int s = 0; s < 32; s++) begin
            vecs.push_back('{s: 5'(s), i: 32'd640, exp: (s == 7 || s == 9)});
        end
        for (int k = 0; k < 32; k++) begin
            one_hot = 32'd1 << k;
            vecs.push_back('{s: 5'(k), i: one_hot, exp: 1'b1});
        end
        for (int k = 0; k < 32; k++) begin
            one_hot = 32'd1 << k;
            vecs.push_back('{s: 5'(k), i: ~one_hot, exp: 1'b0});
        end
        vecs.push_back('{s: 5'd0,  i: 32'h8000_0001, exp: 1'b1});
        vecs.push_back('{s: 5'd31, i: 32'h8000_0001, exp: 1'b1});
        vecs.push_back('{s: 5'd15, i: 32'h8000_0001, exp: 1'b0});
        vecs.push_back('{s: 5'd16, i: 32'h8000_0001, exp: 1'b0});
        vecs.push_back('{s: 5'd31, i: 32'h7fff_ffff, exp: 1'b0});
        vecs.push_back('{s: 5'd16, i: 32'h0001_0000, exp: 1'b1});

        // Reset held for two edges with all-ones lanes.
        rst_n = 1'b0;
        bus.S = 5'd0;
        bus.I = 32'hffff_ffff;
        @(posedge clk);
        #1;
        check("reset_edge1", bus.Y, 1'b0);
        @(posedge clk);
        #1;
        check("reset_edge2", bus.Y, 1'b0);
        rst_n = 1'b1;
        step(5'd7, 32'd640, 1'b1, "release_s7");

        foreach (vecs[n]) begin
            step(vecs[n].s, vecs[n].i, vecs[n].exp, $sformatf("vec%0d", n));
        end

        // Hold: Y=1 latched, then S and I change between edges.
        step(5'd9, 32'd640, 1'b1, "hold_load");
        #2;
        bus.S = 5'd0;
        bus.I = 32'd0;
        #2;
        check("hold_mid_cycle", bus.Y, 1'b1);
        @(posedge clk);
        #1;
        check("hold_next_edge", bus.Y, 1'b0);

        // Simultaneous change of S and I: new S indexes new I.
        step(5'd31, 32'h8000_0000, 1'b1, "simul_change");

        // Mid-stream reset.
        step(5'd9, 32'd640, 1'b1, "midrst_pre");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_assert", bus.Y, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release", bus.Y, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
